// File: rtl/lstm_act_pkg.sv
// Shared types and Q9.7 constants for the LSTM activation sequencers.
package lstm_act_pkg;

    // Sequencer phases: SETUP presents an element, CAPTURE stores its result.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETUP   = 2'd1,
        CAPTURE = 2'd2,
        FIN     = 2'd3
    } seq_state_t;

    // Q9.7 fixed point: 1.0 and 0.0
    localparam logic [15:0] Q7_ONE  = 16'h0080;
    localparam logic [15:0] Q7_ZERO = 16'h0000;

endpackage

// File: rtl/act_seq_buf.sv
// DEPTH x XLEN register buffer, one write port and one read port.
// REG_RD=1 gives a registered read (1-cycle latency, read register cleared
// on reset); REG_RD=0 gives a combinational read. Storage is never reset.
module act_seq_buf #(
    parameter int  DEPTH  = 16,
    parameter int  XLEN   = 16,
    parameter bit  REG_RD = 1'b1,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            we_i,
    input  logic [AW-1:0]   waddr_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic [AW-1:0]   raddr_i,
    output logic [XLEN-1:0] rdata_o
);

    logic [XLEN-1:0] mem_q [DEPTH];

    // Write port; contents survive reset so partial results stay readable.
    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    generate
        if (REG_RD) begin : g_reg_rd
            logic [XLEN-1:0] rdata_q;
            // Registered read: a same-edge write is not visible until the next read.
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) rdata_q <= '0;
                else         rdata_q <= mem_q[raddr_i];
            end
            assign rdata_o = rdata_q;
        end else begin : g_async_rd
            logic unused_rst;
            assign unused_rst = rst_ni;
            assign rdata_o    = mem_q[raddr_i];
        end
    endgenerate

endmodule

// File: rtl/sigmoid_sequencer.sv
// Sigmoid sequencer: streams a buffered vector of Q9.7 pre-activations into
// the sigmoid unit, two cycles per element, and buffers the results.
// Optional feature: define SIGMOID_CLAMP_EN to clamp captured results to
// [0.0, 1.0] and expose a saturating clamp counter on clamp_cnt.
module sigmoid_sequencer
    import lstm_act_pkg::*;
#(
    parameter int  DEPTH = 16,
    parameter int  XLEN  = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [XLEN-1:0] wr_data,
    input  logic            start,
    input  logic [AW:0]     len,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] sig_pkt_out,
    input  logic [XLEN-1:0] sig_pkt_in,
    input  logic [AW-1:0]   rd_addr,
    output logic [XLEN-1:0] rd_data
`ifdef SIGMOID_CLAMP_EN
    ,
    output logic [7:0]      clamp_cnt
`endif
);

    seq_state_t      state_q, state_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [AW:0]     len_q, len_d;
    logic [AW:0]     len_clamped;
    logic            last_elem;
    logic            pkt_en;
    logic            cap_we;
    logic            start_acc;
    logic [XLEN-1:0] in_rdata;
    logic [XLEN-1:0] cap_data;

    assign len_clamped = (len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : len;
    assign last_elem   = ({1'b0, idx_q} == (len_q - (AW+1)'(1)));

    // State, element index and latched length.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
        end
    end

    // Next state and Moore outputs; the element is held over SETUP+CAPTURE
    // because the sigmoid registers its coefficients on the SETUP edge.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        len_d     = len_q;
        busy      = 1'b0;
        done      = 1'b0;
        pkt_en    = 1'b0;
        cap_we    = 1'b0;
        start_acc = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    start_acc = 1'b1;
                    if (len != '0) begin
                        state_d = SETUP;
                        idx_d   = '0;
                        len_d   = len_clamped;
                    end else begin
                        state_d = FIN;
                    end
                end
            end
            SETUP: begin
                busy    = 1'b1;
                pkt_en  = 1'b1;
                state_d = CAPTURE;
            end
            CAPTURE: begin
                busy   = 1'b1;
                pkt_en = 1'b1;
                cap_we = 1'b1;
                if (last_elem) begin
                    state_d = FIN;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = SETUP;
                end
            end
            FIN: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign sig_pkt_out = pkt_en ? in_rdata : '0;

    // Pre-activations; writes are locked out while a pass is streaming.
    act_seq_buf #(.DEPTH(DEPTH), .XLEN(XLEN), .REG_RD(1'b0)) u_in_buf (
        .clk_i   (clock),
        .rst_ni  (reset_n),
        .we_i    (wr_en & ~busy),
        .waddr_i (wr_addr),
        .wdata_i (wr_data),
        .raddr_i (idx_q),
        .rdata_o (in_rdata)
    );

    // Sigmoid results, read back through the registered port.
    act_seq_buf #(.DEPTH(DEPTH), .XLEN(XLEN), .REG_RD(1'b1)) u_res_buf (
        .clk_i   (clock),
        .rst_ni  (reset_n),
        .we_i    (cap_we),
        .waddr_i (idx_q),
        .wdata_i (cap_data),
        .raddr_i (rd_addr),
        .rdata_o (rd_data)
    );

`ifdef SIGMOID_CLAMP_EN
    localparam logic [XLEN-1:0] ONE_X  = XLEN'(Q7_ONE);
    localparam logic [XLEN-1:0] ZERO_X = XLEN'(Q7_ZERO);

    logic       cap_neg, cap_over;
    logic [7:0] clamp_cnt_q, clamp_cnt_d;

    assign cap_neg  = sig_pkt_in[XLEN-1];
    assign cap_over = !cap_neg && (sig_pkt_in > ONE_X);

    // Negative results pin to 0.0, results above 1.0 pin to 1.0.
    always_comb begin
        cap_data = sig_pkt_in;
        if (cap_neg)       cap_data = ZERO_X;
        else if (cap_over) cap_data = ONE_X;
    end

    // Clamp events per pass; restarts on every accepted start, sticks at 255.
    always_comb begin
        clamp_cnt_d = clamp_cnt_q;
        if (start_acc)
            clamp_cnt_d = '0;
        else if (cap_we && (cap_neg || cap_over) && (clamp_cnt_q != 8'hFF))
            clamp_cnt_d = clamp_cnt_q + 8'd1;
    end

    // Clamp counter register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) clamp_cnt_q <= '0;
        else          clamp_cnt_q <= clamp_cnt_d;
    end

    assign clamp_cnt = clamp_cnt_q;
`else
    assign cap_data = sig_pkt_in;
`endif

endmodule

// File: tb/tb_sigmoid_sequencer.sv
// Directed + randomized bench for sigmoid_sequencer with a registered sigmoid stub.
module tb_sigmoid_sequencer;

    localparam int DEPTH = 16;

    logic        clock, reset_n, wr_en, start;
    logic [3:0]  wr_addr, rd_addr;
    logic [15:0] wr_data, sig_pkt_in;
    logic [4:0]  len;
    logic        busy, done;
    logic [15:0] sig_pkt_out, rd_data;
`ifdef SIGMOID_CLAMP_EN
    logic [7:0]  clamp_cnt;
`endif

    int tests = 0;
    int fails = 0;
    int stub_mode = 0;

    logic [15:0] in_model  [DEPTH];
    logic [15:0] res_model [DEPTH];
    bit          res_known [DEPTH];

    sigmoid_sequencer #(.DEPTH(DEPTH), .XLEN(16)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .start       (start),
        .len         (len),
        .busy        (busy),
        .done        (done),
        .sig_pkt_out (sig_pkt_out),
        .sig_pkt_in  (sig_pkt_in),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data)
`ifdef SIGMOID_CLAMP_EN
        ,
        .clamp_cnt   (clamp_cnt)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // mode 0: hard sigmoid 0.5 + x/8 saturated to [0,1]; mode 1: same line, unsaturated
    function automatic logic [15:0] stub_fn(input int mode, input logic [15:0] x);
        int sx, v;
        sx = int'($signed(x));
        v  = 64 + (sx >>> 3);
        if (mode == 0) begin
            if (v < 0)   v = 0;
            if (v > 128) v = 128;
        end
        return v[15:0];
    endfunction

    function automatic logic [15:0] store_fn(input logic [15:0] v);
`ifdef SIGMOID_CLAMP_EN
        if (v[15]) return 16'h0000;
        if (v > 16'h0080) return 16'h0080;
`endif
        return v;
    endfunction

    // Sigmoid stub: registers its result from the presented input each edge.
    always @(posedge clock) sig_pkt_in <= stub_fn(stub_mode, sig_pkt_out);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic write_vec(input int mode);
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clock);
            wr_en   = 1'b1;
            wr_addr = 4'(i);
            wr_data = (mode == 0) ? 16'($urandom) : 16'($signed(16'($urandom_range(0, 2047))) - 16'sd1024);
            in_model[i] = wr_data;
        end
        @(negedge clock);
        wr_en = 1'b0;
    endtask

    task automatic read_all(input string tag);
        for (int i = 0; i < DEPTH; i++) begin
            if (res_known[i]) begin
                rd_addr = 4'(i);
                @(negedge clock);
                chk($sformatf("%s_rd%0d", tag, i), rd_data, res_model[i]);
            end
        end
    endtask

    // Runs one pass from the current negedge; returns at the negedge of the done cycle.
    task automatic run_pass(input int l, input bit disturb, input string tag);
        int n, done_cyc, done_cnt, busy_err, pkt_err, clamps;
        logic [15:0] exp_pkt, old0, raw;
        bit old0_known;
        n = (l > DEPTH) ? DEPTH : l;
        done_cyc = -1; done_cnt = 0; busy_err = 0; pkt_err = 0; clamps = 0;
        old0 = res_model[0];
        old0_known = res_known[0];
        @(negedge clock);
        start   = 1'b1;
        len     = 5'(l);
        rd_addr = 4'd0;
        for (int c = 1; c <= 2*n+1; c++) begin
            @(negedge clock);
            if (c == 1) start = 1'b0;
            if (busy !== (c <= 2*n)) busy_err++;
            exp_pkt = (c <= 2*n) ? in_model[(c-1)/2] : 16'h0000;
            if (sig_pkt_out !== exp_pkt) pkt_err++;
            if (done === 1'b1) begin done_cnt++; done_cyc = c; end
            if (c == 3 && n >= 1 && old0_known) chk({tag, "_rd_same_cycle_old"}, rd_data, old0);
            if (disturb && n >= 2 && c == 3) begin
                start = 1'b1; wr_en = 1'b1; wr_addr = 4'd0; wr_data = ~in_model[0];
            end
            if (disturb && n >= 2 && c == 4) begin
                start = 1'b0; wr_en = 1'b0;
            end
        end
        chk({tag, "_busy"}, busy_err, 0);
        chk({tag, "_pkt"}, pkt_err, 0);
        chk({tag, "_done_cycle"}, done_cyc, 2*n+1);
        chk({tag, "_done_count"}, done_cnt, 1);
        for (int i = 0; i < n; i++) begin
            raw = stub_fn(stub_mode, in_model[i]);
            if (store_fn(raw) !== raw) clamps++;
            res_model[i] = store_fn(raw);
            res_known[i] = 1'b1;
        end
`ifdef SIGMOID_CLAMP_EN
        chk({tag, "_clamp_cnt"}, clamp_cnt, clamps);
`endif
    endtask

    initial begin
        int dcnt;
        reset_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        start = 1'b0; len = '0; rd_addr = '0;
        for (int i = 0; i < DEPTH; i++) begin res_known[i] = 1'b0; in_model[i] = '0; res_model[i] = '0; end
        #2;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_pkt", sig_pkt_out, 0);
        chk("reset_rd_data", rd_data, 0);
        @(negedge clock); @(negedge clock);
        reset_n = 1'b1;

        // Directed 3-element pass with hard sigmoid stub
        stub_mode = 0;
        write_vec(0);
        in_model[0] = 16'h0200; in_model[1] = 16'hFE00; in_model[2] = 16'h0000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            wr_en = 1'b1; wr_addr = 4'(i); wr_data = in_model[i];
        end
        @(negedge clock); wr_en = 1'b0;
        run_pass(3, 1'b0, "len3");
        rd_addr = 4'd0; @(negedge clock); chk("len3_r0", rd_data, 16'h0080);
        rd_addr = 4'd1; @(negedge clock); chk("len3_r1", rd_data, 16'h0000);
        rd_addr = 4'd2; @(negedge clock); chk("len3_r2", rd_data, 16'h0040);

        // Oversized length clamps to DEPTH; start/wr_en during busy ignored
        write_vec(0);
        run_pass(20, 1'b1, "len20");
        read_all("len20");

        // Zero length: immediate done, results untouched
        run_pass(0, 1'b0, "len0");
        read_all("len0");

        // Out-of-range sigmoid results
        stub_mode = 1;
        @(negedge clock);
        wr_en = 1'b1; wr_addr = 4'd0; wr_data = 16'h0280; in_model[0] = 16'h0280;
        @(negedge clock);
        wr_addr = 4'd1; wr_data = 16'hFD80; in_model[1] = 16'hFD80;
        @(negedge clock); wr_en = 1'b0;
        run_pass(2, 1'b0, "clamp");
        rd_addr = 4'd0; @(negedge clock);
`ifdef SIGMOID_CLAMP_EN
        chk("clamp_r0", rd_data, 16'h0080);
        rd_addr = 4'd1; @(negedge clock); chk("clamp_r1", rd_data, 16'h0000);
        chk("clamp_cnt2", clamp_cnt, 2);
`else
        chk("clamp_r0", rd_data, 16'h0090);
        rd_addr = 4'd1; @(negedge clock); chk("clamp_r1", rd_data, 16'hFFF0);
`endif

        // Randomized passes against the model
        for (int r = 0; r < 6; r++) begin
            stub_mode = int'($urandom_range(0, 1));
            write_vec(stub_mode);
            run_pass(int'($urandom_range(0, 31)), 1'($urandom), $sformatf("rnd%0d", r));
            read_all($sformatf("rnd%0d", r));
        end

        // Back-to-back passes: second start in the cycle after FIN
        stub_mode = 0;
        write_vec(0);
        run_pass(4, 1'b0, "b2b_a");
        run_pass(7, 1'b0, "b2b_b");
        read_all("b2b");

        // Reset in the middle of a pass
        write_vec(0);
        @(negedge clock);
        start = 1'b1; len = 5'd5;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clock);
            if (c == 1) start = 1'b0;
        end
        reset_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_pkt", sig_pkt_out, 0);
        chk("midrst_rd_data", rd_data, 0);
`ifdef SIGMOID_CLAMP_EN
        chk("midrst_clamp_cnt", clamp_cnt, 0);
`endif
        for (int i = 0; i < 2; i++) res_model[i] = store_fn(stub_fn(0, in_model[i]));
        @(negedge clock); @(negedge clock);
        reset_n = 1'b1;
        dcnt = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clock);
            if (done !== 1'b0 || busy !== 1'b0) dcnt++;
        end
        chk("midrst_no_done", dcnt, 0);
        read_all("midrst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
